// File: rtl/xor_sweep_pkg.sv
// Shared parameters and types for the XOR operand sweep source.
package xor_sweep_pkg;

  localparam int CNT_W     = 76;
  localparam int DATA_W    = 64;
  localparam int HI_OFFSET = 12;
  localparam int STRIDE_W  = 32;

  // Accepted-pair counter stops here instead of wrapping.
  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/xor_operand_sweep_counter.sv
// Sweep counter: holds the current sweep value and exposes the next value
// (value + stride), its carry-out and whether it reaches the limit.
module sweep_counter
  import xor_sweep_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                advance,
  input  logic [CNT_W-1:0]    load_value,
  input  logic [STRIDE_W-1:0] stride,
  input  logic [CNT_W-1:0]    limit,
  output logic [CNT_W-1:0]    value,
  output logic [CNT_W-1:0]    next_value,
  output logic                carry_out,
  output logic                next_at_limit
);

  logic [CNT_W-1:0] value_reg;
  logic [CNT_W:0]   sum;

  // One bit wider than the counter so a wrap past 2^CNT_W is visible.
  always_comb begin
    sum           = {1'b0, value_reg} + {{(CNT_W + 1 - STRIDE_W){1'b0}}, stride};
    next_value    = sum[CNT_W-1:0];
    carry_out     = sum[CNT_W];
    next_at_limit = (sum[CNT_W-1:0] >= limit);
  end

  // Counter register: load wins over advance; otherwise hold (covers stalls).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_reg <= '0;
    end else if (load) begin
      value_reg <= load_value;
    end else if (advance) begin
      value_reg <= sum[CNT_W-1:0];
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/xor_operand_sweep.sv
// Back-pressure-aware operand source for the 64-bit XOR datapath. Steps a
// wide counter from base by stride up to an exclusive limit and presents
// each value as an (op_a, op_b) pair over valid/ready.
module xor_operand_sweep
  import xor_sweep_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    base,
  input  logic [CNT_W-1:0]    limit,
  input  logic [STRIDE_W-1:0] stride,
  output logic [DATA_W-1:0]   op_a,
  output logic [DATA_W-1:0]   op_b,
  output logic                op_valid,
  input  logic                op_ready,
  output logic                busy,
  output logic                done,
  output logic [31:0]         count
);

  state_t              state_reg;
  state_t              state_next;
  logic [CNT_W-1:0]    limit_reg;
  logic [STRIDE_W-1:0] stride_reg;
  logic [31:0]         count_reg;
  logic                load;
  logic                advance;
  logic                handshake;
  logic [CNT_W-1:0]    cnt_value;
  logic [CNT_W-1:0]    cnt_next_value;
  logic                cnt_carry;
  logic                cnt_next_at_limit;

  assign handshake = (state_reg == ST_RUN) && op_ready;

  sweep_counter u_counter (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (load),
    .advance       (advance),
    .load_value    (base),
    .stride        (stride_reg),
    .limit         (limit_reg),
    .value         (cnt_value),
    .next_value    (cnt_next_value),
    .carry_out     (cnt_carry),
    .next_at_limit (cnt_next_at_limit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic plus counter load/advance strobes.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    advance    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (base >= limit) begin
            state_next = ST_DONE;
          end else begin
            load       = 1'b1;
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // abort overrides where a same-cycle handshake would have gone
        if (abort) begin
          state_next = ST_IDLE;
        end else if (handshake) begin
          if (cnt_carry || cnt_next_at_limit) begin
            state_next = ST_DONE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Sweep parameters captured at start; a zero stride becomes one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limit_reg  <= '0;
      stride_reg <= '0;
    end else if ((state_reg == ST_IDLE) && start) begin
      limit_reg  <= limit;
      stride_reg <= (stride == '0) ? {{(STRIDE_W - 1){1'b0}}, 1'b1} : stride;
    end
  end

  // Accepted-pair count: cleared on start, saturating, held after the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if ((state_reg == ST_IDLE) && start) begin
      count_reg <= '0;
    end else if (handshake && (count_reg != COUNT_MAX)) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign op_a     = cnt_value[DATA_W-1:0];
  assign op_b     = cnt_value[CNT_W-1:HI_OFFSET];
  assign op_valid = (state_reg == ST_RUN);
  assign busy     = (state_reg == ST_RUN);
  assign done     = (state_reg == ST_DONE);
  assign count    = count_reg;

endmodule

// File: tb/tb_xor_operand_sweep.sv
// Directed bench for xor_operand_sweep: table of whole sweeps plus
// hand-written abort and reset sequences.
module tb_xor_operand_sweep;
  import xor_sweep_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                abort;
  logic [CNT_W-1:0]    base;
  logic [CNT_W-1:0]    limit;
  logic [STRIDE_W-1:0] stride;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic                op_valid;
  logic                op_ready;
  logic                busy;
  logic                done;
  logic [31:0]         count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xor_operand_sweep dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .base     (base),
    .limit    (limit),
    .stride   (stride),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  typedef struct {
    string               name;
    logic [CNT_W-1:0]    base;
    logic [CNT_W-1:0]    limit;
    logic [STRIDE_W-1:0] stride;
    bit                  bp;
    int                  exp_pairs;
    logic [DATA_W-1:0]   fa, fb, sa, sb, la, lb;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic run_sweep(input vec_t v);
    logic [DATA_W-1:0] qa[$];
    logic [DATA_W-1:0] qb[$];
    logic [DATA_W-1:0] ma[$];
    logic [DATA_W-1:0] mb[$];
    logic [CNT_W:0]    m;
    logic [CNT_W:0]    st;
    logic [DATA_W-1:0] pa, pb;
    bit                prev_stall;
    bit                rdy;
    int                cyc, last_hs, done_cyc, first_valid, stab_err, seq_err;

    // Reference sequence of accepted pairs.
    st = (v.stride == '0) ? 77'd1 : {45'd0, v.stride};
    m  = {1'b0, v.base};
    while (m[CNT_W] == 1'b0 && m[CNT_W-1:0] < v.limit) begin
      ma.push_back(m[DATA_W-1:0]);
      mb.push_back(m[CNT_W-1:HI_OFFSET]);
      m = m + st;
    end

    @(negedge clk);
    base = v.base; limit = v.limit; stride = v.stride; start = 1'b1; op_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; last_hs = 0; done_cyc = -1; first_valid = -1;
    stab_err = 0; prev_stall = 1'b0; pa = '0; pb = '0;
    while (cyc < 20000) begin
      if (done) begin
        done_cyc = cyc;
        chk({v.name, " valid_at_done"}, {63'd0, op_valid}, 64'd0);
        break;
      end
      if (op_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall && op_valid && (op_a !== pa || op_b !== pb)) stab_err++;
      rdy = v.bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      op_ready = rdy;
      if (op_valid && rdy) begin
        qa.push_back(op_a);
        qb.push_back(op_b);
        last_hs = cyc;
      end
      prev_stall = op_valid && !rdy;
      pa = op_a; pb = op_b;
      @(negedge clk);
      cyc++;
    end
    op_ready = 1'b0;

    chk({v.name, " done_timing"}, 64'(done_cyc), 64'(last_hs + 1));
    chk({v.name, " pairs"}, 64'(qa.size()), 64'(v.exp_pairs));
    chk({v.name, " count"}, {32'd0, count}, 64'(v.exp_pairs));
    chk({v.name, " stable_errs"}, 64'(stab_err), 64'd0);
    seq_err = 0;
    if (qa.size() != ma.size()) seq_err = 1;
    else for (int i = 0; i < qa.size(); i++)
      if (qa[i] !== ma[i] || qb[i] !== mb[i]) seq_err++;
    chk({v.name, " seq_errs"}, 64'(seq_err), 64'd0);
    if (v.exp_pairs > 0 && qa.size() > 0) begin
      chk({v.name, " first_valid_cyc"}, 64'(first_valid), 64'd1);
      chk({v.name, " first_a"}, qa[0], v.fa);
      chk({v.name, " first_b"}, qb[0], v.fb);
      chk({v.name, " last_a"}, qa[qa.size()-1], v.la);
      chk({v.name, " last_b"}, qb[qb.size()-1], v.lb);
    end
    if (v.exp_pairs > 1 && qa.size() > 1) begin
      chk({v.name, " second_a"}, qa[1], v.sa);
      chk({v.name, " second_b"}, qb[1], v.sb);
    end
    @(negedge clk);
    chk({v.name, " done_one_cycle"}, {63'd0, done}, 64'd0);
    $display("sweep %s: pairs=%0d count=%0d done_cyc=%0d", v.name, qa.size(), count, done_cyc);
  endtask

  initial begin
    vecs[0] = '{"nominal", 76'd0, 76'd4294967295, 32'd1000000, 1'b0, 4295,
                64'h0, 64'h0, 64'hF4240, 64'hF4, 64'hFFF13D80, 64'hFFF13};
    vecs[1] = '{"backpressure", 76'd0, 76'd4294967295, 32'd1000000, 1'b1, 4295,
                64'h0, 64'h0, 64'hF4240, 64'hF4, 64'hFFF13D80, 64'hFFF13};
    vecs[2] = '{"empty", 76'd10, 76'd10, 32'd1, 1'b0, 0,
                64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    vecs[3] = '{"carry", 76'hFFFFFFFFFFF80000000, 76'hFFFFFFFFFFFFFFFFFFF, 32'h80000000, 1'b0, 1,
                64'hFFFFFFFF80000000, 64'hFFFFFFFFFFF80000, 64'h0, 64'h0,
                64'hFFFFFFFF80000000, 64'hFFFFFFFFFFF80000};
    vecs[4] = '{"zero_stride", 76'd5, 76'd8, 32'd0, 1'b1, 3,
                64'd5, 64'd0, 64'd6, 64'd0, 64'd7, 64'd0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op_ready = 1'b0;
    base = '0; limit = '0; stride = '0;
    #2;
    chk("reset_valid", {63'd0, op_valid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_count", {32'd0, count}, 64'd0);
    chk("reset_op_a", op_a, 64'd0);
    chk("reset_op_b", op_b, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_sweep(vecs[i]);

    // Abort after three handshakes.
    @(negedge clk);
    base = 76'd0; limit = 76'd100; stride = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_ready = 1'b1;
    repeat (3) @(negedge clk);
    op_ready = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", {63'd0, op_valid}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_count", {32'd0, count}, 64'd3);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", {63'd0, done}, 64'd0);
    end
    $display("abort: count=%0d valid=%0d", count, op_valid);

    // Reset in the middle of a sweep, then restart.
    base = 76'h100; limit = 76'h200; stride = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, op_valid}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_count", {32'd0, count}, 64'd0);
    chk("midrst_op_a", op_a, 64'd0);
    chk("midrst_op_b", op_b, 64'd0);
    op_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_valid", {63'd0, op_valid}, 64'd1);
    chk("restart_op_a", op_a, 64'h100);
    chk("restart_count", {32'd0, count}, 64'd0);
    $display("restart: op_a=%0h count=%0d", op_a, count);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
